parser_input_arbiter: RTL and testbench
=======================================

PARSER_INPUT_ARBITER -- requirements
Module: parser_input_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of packet sources sharing one packet parser; legal range 2..8.
REQ-002 SHALL have parameter ID_W, default 2, width of the requester index; set to ceil(log2(NUM_REQ)).
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-source packet valid.
REQ-006 SHALL have port req_src_ip  input  NUM_REQ*32  per-source source IP; source i occupies bits [32i+31:32i].
REQ-007 SHALL have port req_dst_ip  input  NUM_REQ*32  per-source destination IP; same packing as req_src_ip.
REQ-008 SHALL have port req_src_port  input  NUM_REQ*16  per-source source port; source i occupies bits [16i+15:16i].
REQ-009 SHALL have port req_dst_port  input  NUM_REQ*16  per-source destination port; same packing as req_src_port.
REQ-010 SHALL have port req_ready  output  NUM_REQ  per-source accept strobe.
REQ-011 SHALL have port pkt_valid  output  1  packet valid toward the parser.
REQ-012 SHALL have ports src_ip_int (32), dst_ip_int (32), src_port (16), dst_port (16), all output; the registered fields of the granted packet.
REQ-013 SHALL have port pkt_id  output  ID_W  index of the source that owns the current packet.
REQ-014 SHALL have port pkt_ready  input  1  parser ready.
REQ-015 SHALL have port busy  output  1  high while a packet is held for the parser (state ARB_HOLD).

Function
REQ-016 SHALL implement the FSM ARB_IDLE -> ARB_HOLD -> ARB_IDLE.
REQ-017 ARB_IDLE, any req_valid high: SHALL grant exactly one source by round-robin.
  - Search order starts at last_grant+1, modulo NUM_REQ.
  - Grant is combinational from req_valid and last_grant.
REQ-018 In ARB_IDLE, req_ready[g] SHALL be high only for granted source g in that cycle; all other req_ready bits SHALL be low.
  - Accept = req_valid[g] & req_ready[g].
REQ-019 On accept: SHALL register source g's four fields and g into the output registers, set pkt_valid=1 and go to ARB_HOLD.
  - pkt_valid rises on the edge following accept (latency 1 cycle).
REQ-020 In ARB_HOLD: req_ready SHALL be all-zero; pkt_valid, the four fields and pkt_id SHALL stay stable until pkt_valid & pkt_ready.
REQ-021 On pkt_valid & pkt_ready: SHALL clear pkt_valid, load last_grant with pkt_id and return to ARB_IDLE on that edge.
  - Minimum packet period: 2 cycles.
REQ-022 No req_valid high in ARB_IDLE: SHALL stay in ARB_IDLE; last_grant and the output registers SHALL hold.
REQ-023 Wrap-around: after source NUM_REQ-1 is served, the search SHALL start at source 0.
REQ-024 A source whose req_valid drops before it is granted SHALL lose nothing; it is simply skipped.
REQ-025 A source SHALL NOT be granted twice in a row while another source is valid.
REQ-026 pkt_ready high while pkt_valid is low SHALL have no effect.

Reset
REQ-027 While rst_n is low, SHALL force:
  - state = ARB_IDLE, pkt_valid = 0, busy = 0, pkt_id = 0;
  - fields = 0, last_grant = NUM_REQ-1, so source 0 wins first.
REQ-028 Reset during ARB_HOLD SHALL drop the held packet with no handshake toward the parser; req_ready SHALL be 0 while rst_n is low.

Configuration
REQ-029 With macro PARSER_ARB_STATS_EN defined, SHALL add:
  - input stats_clr (1) and output grant_cnt (NUM_REQ*16);
  - per source, a 16-bit counter incremented on each accept for that source, saturating at 16'hFFFF;
  - all counters zeroed by reset and by stats_clr; stats_clr wins over a simultaneous accept.
REQ-030 Without PARSER_ARB_STATS_EN: stats_clr, grant_cnt and all counter logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-031 After reset, req_valid=4'b1111, pkt_ready=1 -> pkt_id sequence 0,1,2,3,0; one pkt_valid pulse every 2 cycles.
REQ-032 req_valid=4'b0100, src_ip 0xC0A80001, dst_ip 0x0A000002, ports 1234/80 -> next cycle: pkt_valid=1, pkt_id=2, outputs equal those four values.
REQ-033 pkt_ready=0 for 5 cycles in ARB_HOLD -> pkt_valid and fields stable, req_ready=0, busy=1; pkt_ready=1 -> pkt_valid low the next cycle.
REQ-034 last_grant=1, req_valid=4'b0011 -> source 0 granted, then source 1.
REQ-035 rst_n low mid-ARB_HOLD -> pkt_valid=0 immediately; first grant after release goes to the lowest-index valid source.
REQ-036 PARSER_ARB_STATS_EN: 3 accepts from source 1 -> grant_cnt[31:16]=3; stats_clr asserted with a simultaneous accept -> counter reads 0.

Source files
------------

// File: rtl/parser_input_arbiter.sv
// Round-robin arbiter feeding one packet parser from NUM_REQ sources; one packet held at a time.
// Optional per-source grant counters are built when PARSER_ARB_STATS_EN is defined.
module parser_input_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
`ifdef PARSER_ARB_STATS_EN
   input  logic                    stats_clr,
   output logic [NUM_REQ*16-1:0]   grant_cnt,
`endif
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*32-1:0]   req_src_ip,
   input  logic [NUM_REQ*32-1:0]   req_dst_ip,
   input  logic [NUM_REQ*16-1:0]   req_src_port,
   input  logic [NUM_REQ*16-1:0]   req_dst_port,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    pkt_valid,
   output logic [31:0]             src_ip_int,
   output logic [31:0]             dst_ip_int,
   output logic [15:0]             src_port,
   output logic [15:0]             dst_port,
   output logic [ID_W-1:0]         pkt_id,
   input  logic                    pkt_ready,
   output logic                    busy
);

   typedef enum logic {ARB_IDLE, ARB_HOLD} arb_state_e;

   arb_state_e state_q, state_d;
   logic [ID_W-1:0] last_grant;
   logic [ID_W-1:0] grant, hi_sel, lo_sel;
   logic            hi_found, lo_found;
   logic            accept;

   logic [NUM_REQ-1:0][31:0] src_ip_v, dst_ip_v;
   logic [NUM_REQ-1:0][15:0] src_port_v, dst_port_v;

   assign src_ip_v   = req_src_ip;
   assign dst_ip_v   = req_dst_ip;
   assign src_port_v = req_src_port;
   assign dst_port_v = req_dst_port;

   // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid index overall.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_sel   = '0;
      lo_sel   = '0;
      for (int i = NUM_REQ-1; i >= 0; i--) begin
         if (req_valid[i]) begin
            lo_found = 1'b1;
            lo_sel   = ID_W'(i);
            if (ID_W'(i) > last_grant) begin
               hi_found = 1'b1;
               hi_sel   = ID_W'(i);
            end
         end
      end
      grant = hi_found ? hi_sel : lo_sel;
   end

   assign accept = (state_q == ARB_IDLE) && lo_found;

   always_comb begin
      req_ready = '0;
      if (rst_n && accept)
         req_ready[grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ARB_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (lo_found)  state_d = ARB_HOLD;
         ARB_HOLD: if (pkt_ready) state_d = ARB_IDLE;
         default:                 state_d = ARB_IDLE;
      endcase
   end

   assign pkt_valid = (state_q == ARB_HOLD);
   assign busy      = (state_q == ARB_HOLD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src_ip_int <= '0;
         dst_ip_int <= '0;
         src_port   <= '0;
         dst_port   <= '0;
         pkt_id     <= '0;
         last_grant <= ID_W'(NUM_REQ-1);
      end else if (accept) begin
         src_ip_int <= src_ip_v[grant];
         dst_ip_int <= dst_ip_v[grant];
         src_port   <= src_port_v[grant];
         dst_port   <= dst_port_v[grant];
         pkt_id     <= grant;
      end else if ((state_q == ARB_HOLD) && pkt_ready) begin
         last_grant <= pkt_id;
      end
   end

`ifdef PARSER_ARB_STATS_EN
   logic [NUM_REQ-1:0][15:0] cnt;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
      // Clear has priority over a same-cycle accept; counters saturate.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt[g] <= '0;
         else if (stats_clr)
            cnt[g] <= '0;
         else if (accept && (grant == ID_W'(g)) && (cnt[g] != 16'hFFFF))
            cnt[g] <= cnt[g] + 16'd1;
      end
   end

   assign grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_parser_input_arbiter.sv
// Directed bench for parser_input_arbiter; accepted packets are checked against a scoreboard queue.
module tb_parser_input_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ*32-1:0] req_src_ip, req_dst_ip;
   logic [NUM_REQ*16-1:0] req_src_port, req_dst_port;
   logic [NUM_REQ-1:0]    req_ready;
   logic                  pkt_valid, pkt_ready, busy;
   logic [31:0]           src_ip_int, dst_ip_int;
   logic [15:0]           src_port, dst_port;
   logic [ID_W-1:0]       pkt_id;
`ifdef PARSER_ARB_STATS_EN
   logic                  stats_clr;
   logic [NUM_REQ*16-1:0] grant_cnt;
`endif

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     s;
      logic [31:0]     d;
      logic [15:0]     sp;
      logic [15:0]     dp;
   } pkt_t;

   pkt_t        exp_q[$];
   logic [31:0] m_src[NUM_REQ], m_dst[NUM_REQ];
   logic [15:0] m_sp[NUM_REQ], m_dp[NUM_REQ];
   int          n_chk = 0;
   int          n_fail = 0;

   parser_input_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef PARSER_ARB_STATS_EN
      .stats_clr(stats_clr), .grant_cnt(grant_cnt),
`endif
      .req_valid(req_valid), .req_src_ip(req_src_ip), .req_dst_ip(req_dst_ip),
      .req_src_port(req_src_port), .req_dst_port(req_dst_port), .req_ready(req_ready),
      .pkt_valid(pkt_valid), .src_ip_int(src_ip_int), .dst_ip_int(dst_ip_int),
      .src_port(src_port), .dst_port(dst_port), .pkt_id(pkt_id),
      .pkt_ready(pkt_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int i, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] sp, input logic [15:0] dp);
      m_src[i] = s; m_dst[i] = d; m_sp[i] = sp; m_dp[i] = dp;
      req_src_ip[32*i +: 32]   = s;
      req_dst_ip[32*i +: 32]   = d;
      req_src_port[16*i +: 16] = sp;
      req_dst_port[16*i +: 16] = dp;
   endtask

   task automatic push_exp(input int i);
      pkt_t p;
      p.id = ID_W'(i); p.s = m_src[i]; p.d = m_dst[i]; p.sp = m_sp[i]; p.dp = m_dp[i];
      exp_q.push_back(p);
   endtask

   task automatic next();
      @(posedge clk); #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Every completed handshake must match the oldest expected packet.
   always @(negedge clk) begin
      if (rst_n && pkt_valid && pkt_ready) begin
         chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            pkt_t e;
            e = exp_q.pop_front();
            chk("sb_id", 32'(pkt_id), 32'(e.id));
            chk("sb_src_ip", src_ip_int, e.s);
            chk("sb_dst_ip", dst_ip_int, e.d);
            chk("sb_src_port", 32'(src_port), 32'(e.sp));
            chk("sb_dst_port", 32'(dst_port), 32'(e.dp));
         end
      end
   end

   initial begin
      req_src_ip = '0; req_dst_ip = '0; req_src_port = '0; req_dst_port = '0;
      for (int i = 0; i < NUM_REQ; i++)
         set_src(i, 32'hA000_0000 | 32'(i), 32'hB000_0000 | 32'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i));
`ifdef PARSER_ARB_STATS_EN
      stats_clr = 1'b0;
`endif
      // Reset values, with all sources requesting
      rst_n = 1'b0; req_valid = '1; pkt_ready = 1'b0;
      repeat (2) @(posedge clk);
      mid();
      chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pkt_id", 32'(pkt_id), 32'd0);
      chk("rst_src_ip", src_ip_int, 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = '0;
      rst_n = 1'b1;
      next();

      // All valid: ids 0,1,2,3,0 with a pulse every 2 cycles
      req_valid = 4'b1111; pkt_ready = 1'b1;
      push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
      for (int c = 0; c < 10; c++) begin
         mid();
         chk("rr_pkt_valid", 32'(pkt_valid), 32'(c % 2));
         if (c % 2 == 0) chk("rr_req_ready", 32'(req_ready), 32'(1 << ((c / 2) % 4)));
         next();
      end
      req_valid = '0;

      // Single source 2, then held for the parser
      set_src(2, 32'hC0A8_0001, 32'h0A00_0002, 16'd1234, 16'd80);
      req_valid = 4'b0100; pkt_ready = 1'b0;
      push_exp(2);
      mid();
      chk("one_req_ready", 32'(req_ready), 32'b0100);
      next();
      req_valid = 4'b1111;
      mid();
      chk("one_pkt_valid", 32'(pkt_valid), 32'd1);
      chk("one_pkt_id", 32'(pkt_id), 32'd2);
      chk("one_src_ip", src_ip_int, 32'hC0A8_0001);
      chk("one_dst_ip", dst_ip_int, 32'h0A00_0002);
      chk("one_src_port", 32'(src_port), 32'd1234);
      chk("one_dst_port", 32'(dst_port), 32'd80);
      repeat (5) begin
         next(); mid();
         chk("hold_pkt_valid", 32'(pkt_valid), 32'd1);
         chk("hold_busy", 32'(busy), 32'd1);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
         chk("hold_src_ip", src_ip_int, 32'hC0A8_0001);
         chk("hold_pkt_id", 32'(pkt_id), 32'd2);
      end
      next();
      pkt_ready = 1'b1; req_valid = '0;
      next(); mid();
      chk("release_pkt_valid", 32'(pkt_valid), 32'd0);
      chk("release_busy", 32'(busy), 32'd0);

      // Make last_grant 1, then sources 0 and 1: 0 first, then 1
      next();
      req_valid = 4'b0010;
      push_exp(1); push_exp(0); push_exp(1);
      mid();
      chk("lg1_req_ready", 32'(req_ready), 32'b0010);
      next();
      req_valid = 4'b0011;
      next(); mid();
      chk("rr_wrap_0", 32'(req_ready), 32'b0001);
      next(); next(); mid();
      chk("rr_then_1", 32'(req_ready), 32'b0010);
      next();
      req_valid = '0;
      next();

      // Reset while holding a packet from source 3
      req_valid = 4'b1000; pkt_ready = 1'b0;
      next(); mid();
      chk("pre_rst_pkt_valid", 32'(pkt_valid), 32'd1);
      chk("pre_rst_pkt_id", 32'(pkt_id), 32'd3);
      rst_n = 1'b0; req_valid = 4'b1010;
      #1;
      chk("mid_rst_pkt_valid", 32'(pkt_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_pkt_id", 32'(pkt_id), 32'd0);
      chk("mid_rst_src_ip", src_ip_int, 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; pkt_ready = 1'b1;
      push_exp(1);
      #1;
      chk("post_rst_lowest", 32'(req_ready), 32'b0010);
      next();
      req_valid = '0;
      next();

`ifdef PARSER_ARB_STATS_EN
      stats_clr = 1'b1;
      next();
      stats_clr = 1'b0;
      mid();
      chk("cnt_cleared", 32'(grant_cnt[31:16]), 32'd0);
      req_valid = 4'b0010;
      push_exp(1); push_exp(1); push_exp(1);
      repeat (5) next();
      req_valid = '0;
      next(); mid();
      chk("cnt_three", 32'(grant_cnt[31:16]), 32'd3);
      req_valid = 4'b0010; stats_clr = 1'b1;
      push_exp(1);
      next();
      stats_clr = 1'b0; req_valid = '0;
      mid();
      chk("cnt_clr_wins", 32'(grant_cnt[31:16]), 32'd0);
      chk("cnt_clr_pkt_valid", 32'(pkt_valid), 32'd1);
      next(); next();
`endif

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
